// File: rtl/alu_seq_pkg.sv
// Shared opcode map and FSM state encoding for the sequential ALU core.
package alu_seq_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_CMP  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_XOR  = 4'h7;
    localparam logic [3:0] OP_NAND = 4'h8;
    localparam logic [3:0] OP_NOR  = 4'h9;
    localparam logic [3:0] OP_XNOR = 4'hA;
    localparam logic [3:0] OP_NOT  = 4'hB;
    localparam logic [3:0] OP_NEG  = 4'hC;
    localparam logic [3:0] OP_STO  = 4'hD;
    localparam logic [3:0] OP_SWP  = 4'hE;
    localparam logic [3:0] OP_MOV  = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_ops.sv
// Single-cycle result and flag generation for every non-shift opcode.
module alu_seq_ops
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             z,
    output logic             c,
    output logic             n,
    output logic             v
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] neg;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign neg  = {(WIDTH+1){1'b0}} - {1'b0, a};

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                y = diff[WIDTH-1:0];
                c = diff[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
                y = {{(WIDTH-3){1'b0}}, (a > b), (a == b), (a < b)};
                c = (a < b);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_NEG: begin
                y = neg[WIDTH-1:0];
                c = (a != '0);
                // Only the most negative value maps onto itself.
                v = a[WIDTH-1] && y[WIDTH-1];
            end
            OP_MOV:  y = b;
            default: y = '0;
        endcase
    end

    // CMP reports equality on Z; its encoded Y is never zero.
    assign z = (op == OP_CMP) ? (a == b) : (y == '0);
    assign n = y[WIDTH-1];

endmodule

// File: rtl/alu_seq_core.sv
// Operand/result registers, start/busy/done FSM and bit-serial shifter.
module alu_seq_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] din,
    input  logic             load_a,
    input  logic             load_b,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] y_out,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_n,
    output logic             flag_v,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] a_reg, b_reg, y_reg;
    logic [SHW-1:0]   count_reg;
    logic             z_reg, c_reg, n_reg, v_reg, done_reg;

    logic [WIDTH-1:0] ops_y;
    logic             ops_z, ops_c, ops_n, ops_v;

    alu_seq_ops #(.WIDTH(WIDTH)) u_ops (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .y  (ops_y),
        .z  (ops_z),
        .c  (ops_c),
        .n  (ops_n),
        .v  (ops_v)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = EXEC;
            EXEC: begin
                if (is_shift(op_reg) && (b_reg[SHW-1:0] != '0))
                    state_next = SHIFT;
                else
                    state_next = DONE;
            end
            SHIFT: if (count_reg == SHW'(1)) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            y_reg     <= '0;
            count_reg <= '0;
            z_reg     <= 1'b0;
            c_reg     <= 1'b0;
            n_reg     <= 1'b0;
            v_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Registered so done rises together with the final Z/N update.
            done_reg  <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (load_a) a_reg <= din;
                    if (load_b) b_reg <= din;
                    if (start)  op_reg <= opcode;
                end
                EXEC: begin
                    if (is_shift(op_reg)) begin
                        y_reg     <= a_reg;
                        count_reg <= b_reg[SHW-1:0];
                        c_reg     <= 1'b0;
                        v_reg     <= 1'b0;
                    end else if (op_reg == OP_STO) begin
                        a_reg <= y_reg;
                    end else if (op_reg == OP_SWP) begin
                        a_reg <= b_reg;
                        b_reg <= a_reg;
                    end else begin
                        y_reg <= ops_y;
                        z_reg <= ops_z;
                        c_reg <= ops_c;
                        n_reg <= ops_n;
                        v_reg <= ops_v;
                    end
                end
                SHIFT: begin
                    if (op_reg == OP_SHL) begin
                        y_reg <= y_reg << 1;
                        c_reg <= y_reg[WIDTH-1];
                    end else begin
                        y_reg <= y_reg >> 1;
                        c_reg <= y_reg[0];
                    end
                    count_reg <= count_reg - SHW'(1);
                end
                DONE: begin
                    if (is_shift(op_reg)) begin
                        z_reg <= (y_reg == '0);
                        n_reg <= y_reg[WIDTH-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign a_out  = a_reg;
    assign b_out  = b_reg;
    assign y_out  = y_reg;
    assign flag_z = z_reg;
    assign flag_c = c_reg;
    assign flag_n = n_reg;
    assign flag_v = v_reg;
    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;

endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised successor to the board-level 8-bit ALU datapath. It holds operand registers A and B and result register Y, each WIDTH bits wide, and executes a 16-opcode instruction set under a start/busy/done handshake. Shifts are multi-cycle: one bit per clock, by a variable amount. It sits between the switch/button front end (debounced strobes) and the LED/seven-segment display logic, and produces status flags Z/C/N/V.

Parameters:
WIDTH, 8, datapath width in bits (>=4)
SHW, $clog2(WIDTH), width of shift-amount field taken from B[SHW-1:0]

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle strobe; begin operation on opcode
opcode  input  4  operation select, sampled with start
din  input  WIDTH  external operand data
load_a  input  1  strobe: A <= din
load_b  input  1  strobe: B <= din
a_out  output  WIDTH  register A
b_out  output  WIDTH  register B
y_out  output  WIDTH  register Y
flag_z  output  1  zero
flag_c  output  1  carry / borrow / shifted-out bit / lt
flag_n  output  1  negative (Y MSB)
flag_v  output  1  signed overflow
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the result is committed

Behaviour:
- Reset (reset=0, asynchronous): A, B, Y, all flags, busy, done = 0; count = 0; state = IDLE. Applies mid-operation and aborts it; no partial result is kept.
- Opcodes: 0 ADD, 1 SUB (A-B), 2 SHL, 3 SHR (logical), 4 CMP (unsigned), 5 AND, 6 OR, 7 XOR, 8 NAND, 9 NOR, A XNOR, B NOT (~A), C NEG (-A, two's complement), D STO (A <= Y), E SWP (A<->B), F MOV (Y <= B).
- FSM: IDLE -> EXEC -> {SHIFT ->}* DONE -> IDLE.
  - IDLE: start=1 latches opcode, then goes to EXEC.
  - EXEC, non-shift op: commits Y/flags (or A/B for STO/SWP), then goes to DONE.
  - EXEC, shift op: Y <= A; count <= B[SHW-1:0]. Goes to DONE if count==0, else to SHIFT.
  - SHIFT: Y shifts by one bit; C <= bit shifted out; count decrements; goes to DONE when count reaches 1 before the decrement.
  - DONE: done=1 for exactly one cycle; Z/N recomputed from final Y for shifts; returns to IDLE.
- Latency: start sampled at edge k. Non-shift ops: done high during the cycle after edge k+2. Shifts: done high after edge k+2+count.
- Operands are read in EXEC from the registers. A load_a/load_b and a start on the same IDLE edge: the load wins, and the operation uses the newly loaded value.
- load_a, load_b and start are ignored while busy=1. A and B are frozen during an operation.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry-out; V = signed overflow.
  - SUB, NEG: C = borrow (A<B; for NEG, A!=0); V = signed overflow.
  - Z = (Y==0) and N = Y[WIDTH-1] for all Y-writing ops.
- Logic ops and MOV clear C and V.
- CMP: Y = {0..., gt, eq, lt}; Z = eq; C = lt; N = V = 0.
- STO and SWP leave Y and all flags unchanged.
- Shift amount 0: Y = A, C = 0.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_ADD..OP_MOV) and FSM state encoding (IDLE/EXEC/SHIFT/DONE).
- One sub-module, alu_seq_ops: purely combinational. Takes A, B, opcode; returns single-cycle result and next flags. The FSM, registers and shift iterator stay in alu_seq_core.

Test Plan:
1. WIDTH=8; A=0x7F, B=0x01; ADD -> Y=0x80, N=1, V=1, C=0, Z=0; done pulses exactly once, 2 cycles after start.
2. A=0x05, B=0x07; SUB -> Y=0xFE, C=1, N=1, V=0. Then CMP with A=B=0x10 -> Y=0x02, Z=1, C=0.
3. A=0x81, B=0x03; SHL -> busy for 5 cycles, Y=0x08, C=0, done at k+5. Then SHR of A=0x81, B=0x01 -> Y=0x40, C=1.
4. start and load_a pulsed during an active SHL -> both ignored; A unchanged; exactly one done pulse.
5. A=0x12, B=0x34; SWP -> A=0x34, B=0x12, flags unchanged. STO after ADD (Y=0x46) -> A=0x46.
6. reset low mid-shift (count=2) -> all outputs 0 and busy=0 asynchronously. After release, a new ADD completes normally.
